dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the data memory. It shares the single data-memory port between the core load/store stage (M0) and a loader/DMA engine (M1). M0 has fixed priority, bounded by a starvation limit for M1. Each access is sequenced through a registered grant/access/complete handshake, and misaligned accesses are rejected without touching memory.

---
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter with grant/access/complete sequencing
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [DM_ADDRESS-1:0] m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [2:0]            m0_funct3,
    output logic                  m0_gnt,
    output logic                  m0_done,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [DM_ADDRESS-1:0] m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [2:0]            m1_funct3,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic                  m1_err,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    state_t                  state;
    state_t                  state_next;
    logic                    cmd_we;
    logic                    cmd_id;
    logic [DM_ADDRESS-1:0]   cmd_addr;
    logic [DATA_W-1:0]       cmd_wdata;
    logic [2:0]              cmd_funct3;
    logic [3:0]              streak;
    logic                    done_q;
    logic                    done_id;
    logic                    err_q;
    logic                    any_req;
    logic                    pick_m1;
    logic                    decide;
    logic                    cmd_aligned;

    // Arbitration: M0 wins ties unless M1 has waited through MAX_STREAK M0 grants
    always_comb begin
        any_req = m0_req | m1_req;
        pick_m1 = m1_req && (!m0_req || (streak == STREAK_MAX));
        decide  = (state == IDLE) && any_req;
    end

    // Alignment of the latched command; sizes other than half/word are treated as aligned
    always_comb begin
        cmd_aligned = 1'b1;
        case (cmd_funct3)
            3'b001:  cmd_aligned = !cmd_addr[0];
            3'b010:  cmd_aligned = (cmd_addr[1:0] == 2'b00);
            default: cmd_aligned = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: every access occupies exactly one ACCESS cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = any_req ? ACCESS : IDLE;
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: grant and memory strobes during ACCESS, done/err from the completion register
    always_comb begin
        m0_gnt     = (state == ACCESS) && !cmd_id;
        m1_gnt     = (state == ACCESS) && cmd_id;
        mem_read   = (state == ACCESS) && !cmd_we && cmd_aligned;
        mem_write  = (state == ACCESS) && cmd_we && cmd_aligned;
        mem_a      = cmd_addr;
        mem_wd     = cmd_wdata;
        mem_funct3 = cmd_funct3;
        m0_done    = done_q && !done_id;
        m1_done    = done_q && done_id;
        m0_err     = done_q && !done_id && err_q;
        m1_err     = done_q && done_id && err_q;
    end

    // Command register and starvation counter, updated at each arbitration decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we     <= 1'b0;
            cmd_id     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_funct3 <= 3'b000;
            streak     <= 4'd0;
        end else if (decide) begin
            cmd_id     <= pick_m1;
            cmd_we     <= pick_m1 ? m1_we     : m0_we;
            cmd_addr   <= pick_m1 ? m1_addr   : m0_addr;
            cmd_wdata  <= pick_m1 ? m1_wdata  : m0_wdata;
            cmd_funct3 <= pick_m1 ? m1_funct3 : m0_funct3;
            if (pick_m1 || !m1_req)
                streak <= 4'd0;
            else if (streak != STREAK_MAX)
                streak <= streak + 4'd1;
        end
    end

    // Completion: one-cycle done after ACCESS, load data captured only for aligned loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            done_id <= 1'b0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            done_q  <= (state == ACCESS);
            done_id <= cmd_id;
            err_q   <= !cmd_aligned;
            if ((state == ACCESS) && !cmd_we && cmd_aligned)
                rdata <= mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven checks of dmem_arbiter arbitration, sequencing and reset
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [8:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [2:0]  m0_funct3, m1_funct3;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] rdata;
    logic        mem_read, mem_write;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd;

    int n_vec;
    int n_miss;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_funct3(m0_funct3), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_funct3(m1_funct3), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    // Memory model: word 0x010..0x013 holds DEADBEEF, elsewhere a tag of the address
    assign mem_rd = (mem_a[8:2] == 7'd4) ? 32'hDEADBEEF : {16'hA5A5, 7'b0, mem_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        r0, we0;
        logic [8:0]  a0;
        logic [31:0] wd0;
        logic [2:0]  f0;
        logic        r1, we1;
        logic [8:0]  a1;
        logic [31:0] wd1;
        logic [2:0]  f1;
        logic        eg0, eg1, erd, ewr;
        logic [8:0]  ea;
        logic [31:0] ewd;
        logic [2:0]  ef;
        logic        eerr;
        logic [31:0] erdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_reqs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_funct3 = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_funct3 = '0;
    endtask

    // One isolated access: returns which requester was granted
    task automatic single(input logic r0, input logic r1, output logic g0, output logic g1);
        m0_req = r0; m0_we = 0; m0_addr = 9'h010; m0_funct3 = 3'b010;
        m1_req = r1; m1_we = 0; m1_addr = 9'h020; m1_funct3 = 3'b010;
        @(posedge clk); @(negedge clk);
        g0 = m0_gnt; g1 = m1_gnt;
        clear_reqs();
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        logic g0, g1;
        logic [1:0] order [16];
        int         when  [16];
        int         ng;
        int         stray;
        logic [1:0] exp_id;

        n_vec = 0;
        n_miss = 0;
        //           r0 we0 a0      wd0           f0    r1 we1 a1      wd1           f1    g0 g1 rd wr ea      ewd           ef    err rdata
        vecs[0] = '{1'b1,1'b0,9'h010,32'h0,        3'd2, 1'b0,1'b0,9'h000,32'h0,        3'd0, 1'b1,1'b0,1'b1,1'b0,9'h010,32'h0,        3'd2, 1'b0,32'hDEADBEEF};
        vecs[1] = '{1'b0,1'b0,9'h000,32'h0,        3'd0, 1'b1,1'b1,9'h005,32'h000000AB, 3'd0, 1'b0,1'b1,1'b0,1'b1,9'h005,32'h000000AB, 3'd0, 1'b0,32'hDEADBEEF};
        vecs[2] = '{1'b1,1'b0,9'h002,32'h0,        3'd2, 1'b0,1'b0,9'h000,32'h0,        3'd0, 1'b1,1'b0,1'b0,1'b0,9'h002,32'h0,        3'd2, 1'b1,32'hDEADBEEF};
        vecs[3] = '{1'b1,1'b0,9'h006,32'h0,        3'd1, 1'b0,1'b0,9'h000,32'h0,        3'd0, 1'b1,1'b0,1'b1,1'b0,9'h006,32'h0,        3'd1, 1'b0,32'hA5A50006};
        vecs[4] = '{1'b0,1'b0,9'h000,32'h0,        3'd0, 1'b1,1'b0,9'h003,32'h0,        3'd1, 1'b0,1'b1,1'b0,1'b0,9'h003,32'h0,        3'd1, 1'b1,32'hA5A50006};
        vecs[5] = '{1'b1,1'b1,9'h00C,32'h12345678, 3'd2, 1'b0,1'b0,9'h000,32'h0,        3'd0, 1'b1,1'b0,1'b0,1'b1,9'h00C,32'h12345678, 3'd2, 1'b0,32'hA5A50006};
        vecs[6] = '{1'b1,1'b0,9'h011,32'h0,        3'd0, 1'b1,1'b0,9'h020,32'h0,        3'd2, 1'b1,1'b0,1'b1,1'b0,9'h011,32'h0,        3'd0, 1'b0,32'hDEADBEEF};
        vecs[7] = '{1'b0,1'b0,9'h000,32'h0,        3'd0, 1'b1,1'b0,9'h003,32'h0,        3'd7, 1'b0,1'b1,1'b1,1'b0,9'h003,32'h0,        3'd7, 1'b0,32'hA5A50003};
        vecs[8] = '{1'b1,1'b1,9'h1FF,32'hCAFEF00D, 3'd0, 1'b0,1'b0,9'h000,32'h0,        3'd0, 1'b1,1'b0,1'b0,1'b1,9'h1FF,32'hCAFEF00D, 3'd0, 1'b0,32'hA5A50003};
        vecs[9] = '{1'b0,1'b0,9'h000,32'h0,        3'd0, 1'b1,1'b1,9'h102,32'h0000BEEF, 3'd1, 1'b0,1'b1,1'b0,1'b1,9'h102,32'h0000BEEF, 3'd1, 1'b0,32'hA5A50003};

        rst_n = 0;
        clear_reqs();
        #12;
        chk("reset_gnt",   {30'b0, m0_gnt, m1_gnt}, 32'd0);
        chk("reset_done",  {28'b0, m0_done, m1_done, m0_err, m1_err}, 32'd0);
        chk("reset_mem",   {30'b0, mem_read, mem_write}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_mem_a", {23'b0, mem_a}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            m0_req = vecs[i].r0; m0_we = vecs[i].we0; m0_addr = vecs[i].a0;
            m0_wdata = vecs[i].wd0; m0_funct3 = vecs[i].f0;
            m1_req = vecs[i].r1; m1_we = vecs[i].we1; m1_addr = vecs[i].a1;
            m1_wdata = vecs[i].wd1; m1_funct3 = vecs[i].f1;
            @(posedge clk); @(negedge clk);
            chk($sformatf("v%0d_m0_gnt", i), {31'b0, m0_gnt}, {31'b0, vecs[i].eg0});
            chk($sformatf("v%0d_m1_gnt", i), {31'b0, m1_gnt}, {31'b0, vecs[i].eg1});
            chk($sformatf("v%0d_mem_read", i), {31'b0, mem_read}, {31'b0, vecs[i].erd});
            chk($sformatf("v%0d_mem_write", i), {31'b0, mem_write}, {31'b0, vecs[i].ewr});
            chk($sformatf("v%0d_mem_a", i), {23'b0, mem_a}, {23'b0, vecs[i].ea});
            chk($sformatf("v%0d_mem_wd", i), mem_wd, vecs[i].ewd);
            chk($sformatf("v%0d_mem_funct3", i), {29'b0, mem_funct3}, {29'b0, vecs[i].ef});
            chk($sformatf("v%0d_early_done", i), {30'b0, m0_done, m1_done}, 32'd0);
            clear_reqs();
            @(posedge clk); @(negedge clk);
            chk($sformatf("v%0d_m0_done", i), {31'b0, m0_done}, {31'b0, vecs[i].eg0});
            chk($sformatf("v%0d_m1_done", i), {31'b0, m1_done}, {31'b0, vecs[i].eg1});
            chk($sformatf("v%0d_m0_err", i), {31'b0, m0_err}, {31'b0, vecs[i].eg0 & vecs[i].eerr});
            chk($sformatf("v%0d_m1_err", i), {31'b0, m1_err}, {31'b0, vecs[i].eg1 & vecs[i].eerr});
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].erdata);
            chk($sformatf("v%0d_idle_strobes", i), {28'b0, m0_gnt, m1_gnt, mem_read, mem_write}, 32'd0);
        end

        // Async reset in the middle of an M1 store
        m1_req = 1; m1_we = 1; m1_addr = 9'h008; m1_wdata = 32'h55; m1_funct3 = 3'b010;
        @(posedge clk); @(negedge clk);
        chk("rst_pre_gnt", {30'b0, m1_gnt, mem_write}, 32'd3);
        #2 rst_n = 0;
        #1;
        chk("rst_gnt_drop", {30'b0, m0_gnt, m1_gnt}, 32'd0);
        chk("rst_write_drop", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_done_drop", {30'b0, m0_done, m1_done}, 32'd0);
        clear_reqs();
        @(negedge clk);
        rst_n = 1;
        stray = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (m0_done || m1_done || m0_gnt || m1_gnt) stray++;
        end
        chk("rst_no_done_after", stray, 0);

        // Three M0-only grants, then M1 alone wins the very next decision
        for (int k = 0; k < 3; k++) begin
            single(1'b1, 1'b0, g0, g1);
            chk($sformatf("m0_only_%0d", k), {30'b0, g0, g1}, 32'd2);
        end
        single(1'b0, 1'b1, g0, g1);
        chk("m1_alone", {30'b0, g0, g1}, 32'd1);

        // Both requesting continuously: M1 gets every fifth grant, grants two cycles apart
        m0_req = 1; m0_we = 0; m0_addr = 9'h010; m0_funct3 = 3'b010;
        m1_req = 1; m1_we = 0; m1_addr = 9'h020; m1_funct3 = 3'b010;
        ng = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); @(negedge clk);
            if ((m0_gnt || m1_gnt) && ng < 16) begin
                order[ng] = {m0_gnt, m1_gnt};
                when[ng] = c;
                ng++;
            end
        end
        clear_reqs();
        chk("starve_count", ng, 10);
        for (int k = 0; k < 10; k++) begin
            exp_id = ((k % 5) == 4) ? 2'b01 : 2'b10;
            if (k < ng) begin
                chk($sformatf("starve_order_%0d", k), {30'b0, order[k]}, {30'b0, exp_id});
                chk($sformatf("starve_cycle_%0d", k), when[k], 2 * k);
            end
        end
        @(posedge clk); @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
